// File: rtl/sprite_pkg.sv
// Shared definitions for the sprite fetch controller: element codes,
// sprite size table, FSM state encoding and the slot record layout.
package sprite_pkg;

  localparam int ADDR_W   = 10;
  localparam int COLOUR_W = 12;
  localparam int COORD_W  = 10;
  localparam int ELEM_W   = 3;

  // Element codes; 4 marks background tiles, which are never fetched here.
  localparam logic [ELEM_W-1:0] ELEM_NONE = 3'd0;
  localparam logic [ELEM_W-1:0] ELEM_1    = 3'd1;
  localparam logic [ELEM_W-1:0] ELEM_2    = 3'd2;
  localparam logic [ELEM_W-1:0] ELEM_3    = 3'd3;
  localparam logic [ELEM_W-1:0] ELEM_BG   = 3'd4;
  localparam logic [ELEM_W-1:0] ELEM_5    = 3'd5;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_SCAN = 3'd1,
    ST_REQ  = 3'd2,
    ST_WAIT = 3'd3,
    ST_OUT  = 3'd4
  } state_t;

  typedef struct packed {
    logic               en;
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
    logic [ELEM_W-1:0]  elem;
  } slot_t;

  // Square sprite edge length per element; zero means "can never hit".
  function automatic logic [4:0] sprite_size(input logic [ELEM_W-1:0] elem);
    case (elem)
      ELEM_1:  sprite_size = 5'd25;
      ELEM_2:  sprite_size = 5'd16;
      ELEM_3:  sprite_size = 5'd20;
      ELEM_5:  sprite_size = 5'd25;
      default: sprite_size = 5'd0;
    endcase
  endfunction

endpackage

// File: rtl/sprite_slot_table.sv
// Sprite slot register file: synchronous write, combinational read.
// Slots at or above SLOTS are not built; writes to them are dropped and
// reads return a disabled record.
module sprite_slot_table
  import sprite_pkg::*;
#(
  parameter int SLOTS = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       we,
  input  logic [2:0] wr_slot,
  input  slot_t      wr_data,
  input  logic [2:0] rd_slot,
  output slot_t      rd_data
);

  slot_t table_w [8];

  genvar gi;
  for (gi = 0; gi < 8; gi++) begin : g_slot
    if (gi < SLOTS) begin : g_live
      slot_t entry_q;
      // Per-slot storage; a write lands on the edge, so same-cycle reads see the old value.
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          entry_q <= '0;
        end else if (we && (wr_slot == 3'(gi))) begin
          entry_q <= wr_data;
        end
      end
      assign table_w[gi] = entry_q;
    end else begin : g_absent
      assign table_w[gi] = '0;
    end
  end

  assign rd_data = table_w[rd_slot];

endmodule

// File: rtl/sprite_fetch_ctrl.sv
// Per-pixel sprite resolver: scans the slot table in priority order,
// fetches the colour of the first covering sprite and falls through
// transparent or timed-out reads to lower-priority slots.
module sprite_fetch_ctrl
  import sprite_pkg::*;
#(
  parameter int             SLOTS       = 8,
  parameter int             TIMEOUT     = 15,
  parameter logic [11:0]    BG_COLOUR   = 12'h000,
  parameter logic [11:0]    TRANSPARENT = 12'hF0F
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                pixel_valid,
  input  logic [COORD_W-1:0]  pixel_x,
  input  logic [COORD_W-1:0]  pixel_y,
  input  logic                cfg_we,
  input  logic [2:0]          cfg_slot,
  input  logic [COORD_W-1:0]  cfg_x,
  input  logic [COORD_W-1:0]  cfg_y,
  input  logic [ELEM_W-1:0]   cfg_element,
  input  logic                cfg_en,
  output logic                read_enable,
  output logic [ADDR_W-1:0]   address_sprite,
  output logic [ELEM_W-1:0]   element,
  input  logic                mem_ready,
  input  logic [COLOUR_W-1:0] mem_data,
  output logic [COLOUR_W-1:0] colour_out,
  output logic                colour_valid,
  output logic                busy,
  output logic                overrun,
  output logic                timeout_err
);

  localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

  state_t              state_q, state_d;
  logic [2:0]          slot_q, slot_d;
  logic [COORD_W-1:0]  px_q, px_d, py_q, py_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [ELEM_W-1:0]   elem_q, elem_d;
  logic [COLOUR_W-1:0] colour_q, colour_d;
  logic [CNT_W-1:0]    wait_q, wait_d;
  logic                overrun_q, overrun_d;
  logic                timeout_q, timeout_d;

  slot_t               rd_slot;
  logic [4:0]          size;
  logic [COORD_W:0]    x_end, y_end;
  logic                hit;
  logic [COORD_W-1:0]  dx, dy;
  logic [ADDR_W-1:0]   addr_calc;
  logic                last_slot;
  logic                mem_accept;
  logic                wait_expired;

  slot_t cfg_rec;
  assign cfg_rec = '{en: cfg_en, x: cfg_x, y: cfg_y, elem: cfg_element};

  sprite_slot_table #(.SLOTS(SLOTS)) u_table (
    .clk     (clk),
    .reset   (reset),
    .we      (cfg_we),
    .wr_slot (cfg_slot),
    .wr_data (cfg_rec),
    .rd_slot (slot_q),
    .rd_data (rd_slot)
  );

  // Hit test and sprite-local address for the slot under compare; sums are
  // one bit wider so sprites near the right/bottom edge do not wrap.
  always_comb begin
    size      = sprite_size(rd_slot.elem);
    x_end     = {1'b0, rd_slot.x} + {6'b0, size};
    y_end     = {1'b0, rd_slot.y} + {6'b0, size};
    hit       = rd_slot.en && (size != 5'd0)
             && ({1'b0, px_q} >= {1'b0, rd_slot.x}) && ({1'b0, px_q} < x_end)
             && ({1'b0, py_q} >= {1'b0, rd_slot.y}) && ({1'b0, py_q} < y_end);
    dx        = px_q - rd_slot.x;
    dy        = py_q - rd_slot.y;
    addr_calc = dy * {5'b0, size} + dx;
  end

  assign last_slot    = (slot_q == 3'(SLOTS - 1));
  assign mem_accept   = ((state_q == ST_REQ) || (state_q == ST_WAIT)) && mem_ready;
  assign wait_expired = (state_q == ST_WAIT) && !mem_ready && (wait_q == CNT_W'(TIMEOUT - 1));

  // State register plus the datapath registers it steers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      slot_q    <= '0;
      px_q      <= '0;
      py_q      <= '0;
      addr_q    <= '0;
      elem_q    <= '0;
      colour_q  <= BG_COLOUR;
      wait_q    <= '0;
      overrun_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      slot_q    <= slot_d;
      px_q      <= px_d;
      py_q      <= py_d;
      addr_q    <= addr_d;
      elem_q    <= elem_d;
      colour_q  <= colour_d;
      wait_q    <= wait_d;
      overrun_q <= overrun_d;
      timeout_q <= timeout_d;
    end
  end

  // Next-state logic: scan, fetch, and fall through on transparent/timeout.
  always_comb begin
    state_d   = state_q;
    slot_d    = slot_q;
    px_d      = px_q;
    py_d      = py_q;
    addr_d    = addr_q;
    elem_d    = elem_q;
    colour_d  = colour_q;
    wait_d    = wait_q;
    overrun_d = overrun_q | (pixel_valid && (state_q != ST_IDLE));
    timeout_d = timeout_q | wait_expired;
    case (state_q)
      ST_IDLE: begin
        if (pixel_valid) begin
          px_d    = pixel_x;
          py_d    = pixel_y;
          slot_d  = '0;
          state_d = ST_SCAN;
        end
      end
      ST_SCAN: begin
        if (hit) begin
          addr_d  = addr_calc;
          elem_d  = rd_slot.elem;
          state_d = ST_REQ;
        end else if (last_slot) begin
          colour_d = BG_COLOUR;
          state_d  = ST_OUT;
        end else begin
          slot_d = slot_q + 3'd1;
        end
      end
      ST_REQ, ST_WAIT: begin
        if (mem_accept && (mem_data != TRANSPARENT)) begin
          colour_d = mem_data;
          state_d  = ST_OUT;
        end else if (mem_accept || wait_expired) begin
          // Transparent or abandoned read: hand over to the next slot.
          if (last_slot) begin
            colour_d = BG_COLOUR;
            state_d  = ST_OUT;
          end else begin
            slot_d  = slot_q + 3'd1;
            state_d = ST_SCAN;
          end
        end else if (state_q == ST_REQ) begin
          wait_d  = '0;
          state_d = ST_WAIT;
        end else begin
          wait_d = wait_q + CNT_W'(1);
        end
      end
      ST_OUT: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Outputs decoded from the current state and the datapath registers.
  always_comb begin
    read_enable    = (state_q == ST_REQ);
    colour_valid   = (state_q == ST_OUT);
    busy           = (state_q != ST_IDLE);
    address_sprite = addr_q;
    element        = elem_q;
    colour_out     = colour_q;
    overrun        = overrun_q;
    timeout_err    = timeout_q;
  end

endmodule

// File: tb/tb_sprite_fetch_ctrl.sv
// Directed bench for sprite_fetch_ctrl with a small reactive memory model.
module tb_sprite_fetch_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        pixel_valid;
  logic [9:0]  pixel_x, pixel_y;
  logic        cfg_we;
  logic [2:0]  cfg_slot;
  logic [9:0]  cfg_x, cfg_y;
  logic [2:0]  cfg_element;
  logic        cfg_en;
  logic        read_enable;
  logic [9:0]  address_sprite;
  logic [2:0]  element;
  logic        mem_ready;
  logic [11:0] mem_data;
  logic [11:0] colour_out;
  logic        colour_valid;
  logic        busy;
  logic        overrun;
  logic        timeout_err;

  int vec_cnt = 0;
  int err_cnt = 0;

  // Memory model settings and per-transaction results.
  int          mem_lat;
  logic [11:0] resp [4];
  int          r_lat, r_nreads, r_ncv;
  logic [11:0] r_col;
  logic [9:0]  r_addr [4];
  logic [2:0]  r_elem [4];

  sprite_fetch_ctrl dut (
    .clk            (clk),
    .reset          (reset),
    .pixel_valid    (pixel_valid),
    .pixel_x        (pixel_x),
    .pixel_y        (pixel_y),
    .cfg_we         (cfg_we),
    .cfg_slot       (cfg_slot),
    .cfg_x          (cfg_x),
    .cfg_y          (cfg_y),
    .cfg_element    (cfg_element),
    .cfg_en         (cfg_en),
    .read_enable    (read_enable),
    .address_sprite (address_sprite),
    .element        (element),
    .mem_ready      (mem_ready),
    .mem_data       (mem_data),
    .colour_out     (colour_out),
    .colour_valid   (colour_valid),
    .busy           (busy),
    .overrun        (overrun),
    .timeout_err    (timeout_err)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic cfg(input logic [2:0] s, input logic [9:0] x, input logic [9:0] y,
                     input logic [2:0] el, input logic en);
    cfg_we = 1'b1; cfg_slot = s; cfg_x = x; cfg_y = y; cfg_element = el; cfg_en = en;
    step();
    cfg_we = 1'b0;
  endtask

  // Issue one pixel and play memory; cycle n is the n-th cycle after the one
  // carrying pixel_valid. inj>0 re-pulses pixel_valid in that cycle.
  task automatic run_pixel(input logic [9:0] x, input logic [9:0] y, input int inj);
    int n, due, ridx, tail;
    r_lat = -1; r_nreads = 0; r_ncv = 0; r_col = 12'hxxx;
    due = -1; ridx = 0; tail = 0; n = 0;
    pixel_x = x; pixel_y = y; pixel_valid = 1'b1;
    while (n < 200 && tail < 12) begin
      step();
      n++;
      pixel_valid = (n == inj);
      mem_ready   = 1'b0;
      if (read_enable) begin
        if (r_nreads < 4) begin
          r_addr[r_nreads] = address_sprite;
          r_elem[r_nreads] = element;
        end
        r_nreads++;
        if (mem_lat >= 0) due = n + mem_lat;
      end
      if (due == n) begin
        mem_ready = 1'b1;
        mem_data  = resp[ridx];
        if (ridx < 3) ridx++;
        due = -1;
      end
      if (colour_valid) begin
        r_ncv++;
        if (r_lat < 0) begin
          r_lat = n;
          r_col = colour_out;
        end
      end
      if (r_lat >= 0) tail++;
    end
    mem_ready = 1'b0;
    $display("pixel (%0d,%0d): reads=%0d latency=%0d colour=%03h strobes=%0d",
             x, y, r_nreads, r_lat, r_col, r_ncv);
  endtask

  initial begin
    reset = 1'b1; pixel_valid = 1'b0; pixel_x = '0; pixel_y = '0;
    cfg_we = 1'b0; cfg_slot = '0; cfg_x = '0; cfg_y = '0; cfg_element = '0; cfg_en = 1'b0;
    mem_ready = 1'b0; mem_data = '0; mem_lat = 2;
    for (int i = 0; i < 4; i++) resp[i] = 12'h000;
    repeat (3) @(negedge clk);

    // Reset state
    check_eq("rst_read_enable", read_enable, 0);
    check_eq("rst_colour_valid", colour_valid, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_overrun", overrun, 0);
    check_eq("rst_timeout", timeout_err, 0);
    check_eq("rst_colour", colour_out, 12'h000);
    check_eq("rst_addr", address_sprite, 0);
    check_eq("rst_element", element, 0);
    reset = 1'b0;
    step();

    // No slots enabled: background after SLOTS+1 cycles, no reads
    run_pixel(10'd50, 10'd50, 0);
    check_eq("empty_latency", r_lat, 9);
    check_eq("empty_colour", r_col, 12'h000);
    check_eq("empty_reads", r_nreads, 0);
    check_eq("empty_strobes", r_ncv, 1);

    // Single hit in slot 0, memory answers after 2 cycles
    cfg(3'd0, 10'd40, 10'd40, 3'd1, 1'b1);
    mem_lat = 2; resp[0] = 12'h0F0;
    run_pixel(10'd45, 10'd42, 0);
    check_eq("hit_reads", r_nreads, 1);
    check_eq("hit_addr", r_addr[0], 55);
    check_eq("hit_element", r_elem[0], 1);
    check_eq("hit_colour", r_col, 12'h0F0);
    check_eq("hit_latency", r_lat, 5);

    // Transparent slot 0 falls through to slot 1
    cfg(3'd0, 10'd0, 10'd0, 3'd2, 1'b1);
    cfg(3'd1, 10'd0, 10'd0, 3'd5, 1'b1);
    resp[0] = 12'hF0F; resp[1] = 12'h00F;
    run_pixel(10'd3, 10'd3, 0);
    check_eq("transp_reads", r_nreads, 2);
    check_eq("transp_addr0", r_addr[0], 51);
    check_eq("transp_addr1", r_addr[1], 78);
    check_eq("transp_elem1", r_elem[1], 5);
    check_eq("transp_colour", r_col, 12'h00F);
    check_eq("transp_latency", r_lat, 9);

    // Background element code never hits
    cfg(3'd1, 10'd0, 10'd0, 3'd5, 1'b0);
    cfg(3'd0, 10'd0, 10'd0, 3'd4, 1'b1);
    run_pixel(10'd1, 10'd1, 0);
    check_eq("elem4_reads", r_nreads, 0);
    check_eq("elem4_colour", r_col, 12'h000);

    // Right-edge sprite: no wrap-around in the bounds compare
    cfg(3'd0, 10'd1015, 10'd0, 3'd2, 1'b1);
    resp[0] = 12'h123;
    run_pixel(10'd1023, 10'd0, 0);
    check_eq("edge_reads", r_nreads, 1);
    check_eq("edge_addr", r_addr[0], 8);
    check_eq("edge_colour", r_col, 12'h123);
    run_pixel(10'd1022, 10'd16, 0);
    check_eq("edge_miss_reads", r_nreads, 0);
    check_eq("edge_miss_colour", r_col, 12'h000);
    check_eq("edge_miss_latency", r_lat, 9);

    // Timeout: REQ at cycle 2, 15 WAIT cycles, slots 1..7 scanned, OUT at 25
    cfg(3'd0, 10'd0, 10'd0, 3'd1, 1'b1);
    check_eq("pre_timeout_flag", timeout_err, 0);
    mem_lat = -1;
    run_pixel(10'd2, 10'd2, 0);
    check_eq("tmo_reads", r_nreads, 1);
    check_eq("tmo_flag", timeout_err, 1);
    check_eq("tmo_colour", r_col, 12'h000);
    check_eq("tmo_latency", r_lat, 25);

    // Overrun: second pixel_valid during WAIT is dropped
    check_eq("pre_overrun_flag", overrun, 0);
    mem_lat = 2; resp[0] = 12'h0F0;
    run_pixel(10'd2, 10'd2, 3);
    check_eq("ovr_flag", overrun, 1);
    check_eq("ovr_strobes", r_ncv, 1);
    check_eq("ovr_colour", r_col, 12'h0F0);
    check_eq("ovr_reads", r_nreads, 1);

    // Reset during WAIT, then a stray mem_ready in IDLE
    pixel_x = 10'd2; pixel_y = 10'd2; pixel_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      pixel_valid = 1'b0;
    end
    check_eq("pre_rst_busy", busy, 1);
    check_eq("pre_rst_wait_no_req", read_enable, 0);
    reset = 1'b1;
    #1;
    check_eq("async_rst_busy", busy, 0);
    step();
    reset = 1'b0;
    mem_ready = 1'b1; mem_data = 12'h0F0;
    step();
    mem_ready = 1'b0;
    check_eq("mid_rst_busy", busy, 0);
    check_eq("mid_rst_colour_valid", colour_valid, 0);
    check_eq("mid_rst_overrun", overrun, 0);
    check_eq("mid_rst_timeout", timeout_err, 0);
    check_eq("mid_rst_colour", colour_out, 12'h000);
    check_eq("mid_rst_addr", address_sprite, 0);
    run_pixel(10'd2, 10'd2, 0);
    check_eq("post_rst_reads", r_nreads, 0);
    check_eq("post_rst_colour", r_col, 12'h000);
    check_eq("post_rst_latency", r_lat, 9);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/sprite_fetch_ctrl.md
SPRITE_FETCH_CTRL -- requirements
Module: sprite_fetch_ctrl

Interface
REQ-001 SHALL have parameter SLOTS, default 8, meaning the number of sprite slots scanned per pixel, from 1 to 8.
REQ-002 SHALL have parameter TIMEOUT, default 15, meaning the maximum number of WAIT cycles allowed per read.
REQ-003 SHALL have parameter BG_COLOUR, default 12'h000, meaning the colour output when no opaque sprite covers the pixel.
REQ-004 SHALL have parameter TRANSPARENT, default 12'hF0F, meaning the colour key that marks a pixel as see-through.
REQ-005 SHALL use one clock; reset is asynchronous and active-high.
REQ-006 clk  in  1  system clock.
REQ-007 reset  in  1  asynchronous, active-high reset.
REQ-008 pixel_valid  in  1  one-cycle strobe meaning pixel_x/pixel_y hold a new pixel.
REQ-009 pixel_x, pixel_y  in  10 each  screen coordinates of the pixel.
REQ-010 cfg_we  in  1  slot-table write strobe.
REQ-011 cfg_slot  in  3  index of the slot being written.
REQ-012 cfg_x, cfg_y  in  10 each  top-left corner of the sprite.
REQ-013 cfg_element  in  3  element code 1..5.
REQ-014 cfg_en  in  1  slot enable.
REQ-015 read_enable  out  1  one-cycle read request to the sprite memory.
REQ-016 address_sprite  out  10  sprite-local pixel address.
REQ-017 element  out  3  element code of the current request.
REQ-018 mem_ready  in  1  the memory colour is valid.
REQ-019 mem_data  in  12  palette colour returned by the memory.
REQ-020 colour_out  out  12  resolved pixel colour.
REQ-021 colour_valid  out  1  one-cycle strobe qualifying colour_out.
REQ-022 busy  out  1  high while the state is not IDLE.
REQ-023 overrun  out  1  sticky flag; set when a pixel_valid is ignored.
REQ-024 timeout_err  out  1  sticky flag; set when a read times out.

Function
REQ-025 SHALL implement the states IDLE, SCAN, REQ, WAIT and OUT.
REQ-026 In IDLE, pixel_valid SHALL latch the pixel coordinates, set the slot index to 0, and move to SCAN.
REQ-027 SCAN SHALL examine one slot per cycle in ascending index order, where slot 0 has the highest priority.
REQ-028 A slot SHALL hit when all of the following hold:
  - the slot is enabled;
  - the element code is 1, 2, 3 or 5;
  - x <= px < x+size;
  - y <= py < y+size.
  The comparisons SHALL use 11-bit sums so that no wrap-around occurs.
REQ-029 The sprite size SHALL come from a table: element 1 is 25, element 2 is 16, element 3 is 20 and element 5 is 25.
REQ-030 Element code 0, 4 (background), 6 and 7 SHALL never hit.
REQ-031 On a hit, SCAN SHALL go to REQ and register address_sprite = (py-y)*size + (px-x) together with element.
REQ-032 REQ SHALL assert read_enable for exactly one cycle and then go to WAIT.
REQ-033 mem_ready SHALL be accepted in either REQ or WAIT.
REQ-034 When mem_ready is accepted with mem_data != TRANSPARENT, the FSM SHALL go to OUT with colour = mem_data.
REQ-035 When mem_ready is accepted with mem_data == TRANSPARENT, the FSM SHALL resume SCAN at the next slot.
REQ-036 When the last slot is examined without an opaque hit, the FSM SHALL go to OUT with colour = BG_COLOUR.
REQ-037 When WAIT lasts TIMEOUT cycles without mem_ready, the FSM SHALL set timeout_err and treat the read as transparent.
REQ-038 OUT SHALL assert colour_valid for one cycle, hold colour_out until the next OUT, and return to IDLE.
REQ-039 Latency with no hit SHALL be SLOTS+1 cycles from the sampled pixel_valid to colour_valid (9 cycles with SLOTS=8).
REQ-040 Latency with an opaque hit at slot k SHALL be k+2 cycles to REQ, plus the memory latency, plus 1 cycle.
REQ-041 pixel_valid arriving while busy SHALL be ignored and SHALL set overrun.
REQ-042 A cfg_we write SHALL take effect on the next clock edge in any state; the slot compare in a given cycle SHALL use the table contents of that cycle.
REQ-043 A simultaneous cfg_we to the slot under compare SHALL compare against the old value.
REQ-044 A cfg_slot value >= SLOTS SHALL be ignored.

Reset
REQ-045 Reset SHALL force:
  - the state to IDLE;
  - all slots disabled;
  - read_enable, colour_valid, busy, overrun and timeout_err to 0;
  - colour_out to BG_COLOUR;
  - address_sprite and element to 0.
REQ-046 Reset asserted mid-read SHALL abandon the request; a mem_ready arriving after reset SHALL be ignored in IDLE.

Structure
REQ-047 The shared package sprite_pkg SHALL hold:
  - the element code constants;
  - the size table function;
  - the state encoding;
  - the ADDR_W=10 and COLOUR_W=12 constants.
REQ-048 A sub-module sprite_slot_table SHALL hold the slot register file, with a synchronous write port and a combinational read port indexed by the slot index.

Verification
REQ-049 The bench SHALL cover no slots enabled: pixel_valid at (50,50) -> colour_valid 9 cycles later with colour_out=12'h000 and read_enable never asserted.
REQ-050 The bench SHALL cover a single hit: slot 0 holds element 1 at (40,40) and pixel (45,42) -> read_enable with address_sprite=55 and element=1; the memory returns 12'h0F0 after 2 cycles -> colour_out=12'h0F0.
REQ-051 The bench SHALL cover the transparency fallthrough:
  - slot 0 (element 2 at (0,0)) returns 12'hF0F;
  - slot 1 (element 5 at (0,0)) returns 12'h00F;
  - the pixel is (3,3);
  - required response: two reads, address 51 then 78, and colour_out=12'h00F.
REQ-052 The bench SHALL cover the right-edge boundary: element 2 at (1015,0); pixel (1023,0) hits with address 8; pixel (1022,16) misses -> BG_COLOUR.
REQ-053 The bench SHALL cover a timeout: a hit with mem_ready held low -> 15 WAIT cycles, timeout_err=1, then BG_COLOUR output.
REQ-054 The bench SHALL cover overrun and reset:
  - a second pixel_valid while busy -> overrun=1 and only one colour_valid;
  - reset asserted during WAIT -> IDLE, all flags 0, and all slots disabled.
